fireball_launcher: RTL and testbench

- Upstream stage of the fireball/alien collision checker: owns the single player fireball and produces the fireball_h_coord/fireball_v_coord pair that the checker compares against the alien box.
- Launches on a fire-button press, moves the fireball up one step per frame, and retires it on a hit or on leaving the top of the screen.
- Enforces a cooldown before the next shot is allowed.

---
 rtl/game_pkg.sv | 23 ++
 rtl/rise_edge_detect.sv | 19 +
 rtl/fireball_launcher.sv | 103 ++++++++++
 tb/tb_fireball_launcher.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game geometry and the fireball state encoding used by the launcher
// and the alien collision checker.
package game_pkg;

  localparam int unsigned COORD_W         = 10;
  localparam int unsigned SCREEN_H        = 640;
  localparam int unsigned SCREEN_V        = 480;
  localparam int unsigned PLAYER_W        = 128;
  localparam int unsigned FIREBALL_W      = 64;
  localparam int unsigned FIREBALL_H      = 64;
  localparam int unsigned ALIEN_W         = 128;
  localparam int unsigned ALIEN_H         = 128;
  localparam int unsigned SPEED           = 4;
  localparam int unsigned COOLDOWN_FRAMES = 8;

  typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} fireball_state_t;

  // Counter width able to hold n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector; history resets high so a level held through reset
// is not seen as an edge.
module rise_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b1;
    else        d_q <= d;
  end

  assign rise_c = d & ~d_q;

endmodule

// File: rtl/fireball_launcher.sv
// Owns the single player fireball: launches on a fire press, climbs SPEED
// pixels per frame, retires on a hit or off the top, then cools down.
module fireball_launcher
  import game_pkg::*;
#(
  parameter int unsigned SCREEN_V        = game_pkg::SCREEN_V,
  parameter int unsigned PLAYER_W        = game_pkg::PLAYER_W,
  parameter int unsigned FIREBALL_W      = game_pkg::FIREBALL_W,
  parameter int unsigned FIREBALL_H      = game_pkg::FIREBALL_H,
  parameter int unsigned SPEED           = game_pkg::SPEED,
  parameter int unsigned COOLDOWN_FRAMES = game_pkg::COOLDOWN_FRAMES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               fire_btn,
  input  logic [COORD_W-1:0] player_h_coord,
  input  logic [COORD_W-1:0] player_v_coord,
  input  logic               hit,
  output logic [COORD_W-1:0] fireball_h_coord,
  output logic [COORD_W-1:0] fireball_v_coord,
  output logic               fireball_active,
  output logic               shot_fired,
  output logic               kill
);

  localparam int unsigned CNT_W  = cnt_width(COOLDOWN_FRAMES);
  localparam int          H_OFF  = (int'(PLAYER_W) - int'(FIREBALL_W)) / 2;

  localparam logic [COORD_W-1:0] H_OFF_C   = COORD_W'(H_OFF);
  localparam logic [COORD_W-1:0] FB_H_C    = COORD_W'(FIREBALL_H);
  localparam logic [COORD_W-1:0] SPEED_C   = COORD_W'(SPEED);
  localparam logic [COORD_W-1:0] PARK_V_C  = COORD_W'(SCREEN_V);
  localparam logic [CNT_W-1:0]   CD_LOAD_C = CNT_W'(COOLDOWN_FRAMES);
  localparam fireball_state_t    RETIRE_ST = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;

  fireball_state_t    state;
  logic [CNT_W-1:0]   cd_cnt;
  logic               fire_rise_c;
  logic [COORD_W-1:0] launch_h_c;
  logic [COORD_W-1:0] launch_v_c;

  rise_edge_detect u_fire_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (fire_btn),
    .rise_c (fire_rise_c)
  );

  // Centre over the player; vertical start clamps at the top instead of wrapping.
  assign launch_h_c = player_h_coord + H_OFF_C;
  assign launch_v_c = (player_v_coord >= FB_H_C) ? (player_v_coord - FB_H_C) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      fireball_h_coord <= '0;
      fireball_v_coord <= PARK_V_C;
      fireball_active  <= 1'b0;
      shot_fired       <= 1'b0;
      kill             <= 1'b0;
      cd_cnt           <= '0;
    end else begin
      shot_fired <= 1'b0;
      kill       <= 1'b0;
      case (state)
        IDLE: begin
          if (fire_rise_c) begin
            state            <= FLYING;
            fireball_active  <= 1'b1;
            shot_fired       <= 1'b1;
            fireball_h_coord <= launch_h_c;
            fireball_v_coord <= launch_v_c;
          end
        end
        FLYING: begin
          // hit outranks the frame step; both retire paths park the coords
          if (hit || (frame_tick && (fireball_v_coord < SPEED_C))) begin
            state            <= RETIRE_ST;
            fireball_active  <= 1'b0;
            kill             <= hit;
            fireball_h_coord <= '0;
            fireball_v_coord <= PARK_V_C;
            cd_cnt           <= CD_LOAD_C;
          end else if (frame_tick) begin
            fireball_v_coord <= fireball_v_coord - SPEED_C;
          end
        end
        COOLDOWN: begin
          if (frame_tick) begin
            cd_cnt <= cd_cnt - CNT_W'(1);
            if (cd_cnt <= CNT_W'(1)) begin
              state  <= IDLE;
              cd_cnt <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fireball_launcher.sv
// Vector/scoreboard bench for fireball_launcher: default build plus a
// zero-cooldown build driven separately.
module tb_fireball_launcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick, fire_btn, hit;
  logic       b_tick, b_fire, b_hit;
  logic [9:0] player_h, player_v;
  logic [9:0] a_h, a_v, b_h, b_v;
  logic       a_act, a_shot, a_kill, b_act, b_shot, b_kill;

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] PV = 10'd480;

  typedef struct {
    string      name;
    logic       on_b;
    logic       fire, tick, hitv;
    logic [9:0] ph, pv;
    logic       act;
    logic [9:0] h, v;
    logic       shot, kill;
  } vec_t;

  typedef struct {
    string       name;
    logic        on_b;
    logic [22:0] bits;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[$];

  fireball_launcher u_dut_a (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .fire_btn(fire_btn),
    .player_h_coord(player_h), .player_v_coord(player_v), .hit(hit),
    .fireball_h_coord(a_h), .fireball_v_coord(a_v), .fireball_active(a_act),
    .shot_fired(a_shot), .kill(a_kill)
  );

  fireball_launcher #(.COOLDOWN_FRAMES(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(b_tick), .fire_btn(b_fire),
    .player_h_coord(player_h), .player_v_coord(player_v), .hit(b_hit),
    .fireball_h_coord(b_h), .fireball_v_coord(b_v), .fireball_active(b_act),
    .shot_fired(b_shot), .kill(b_kill)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input string name, input logic on_b, input logic f,
                              input logic t, input logic hv, input int ph, input int pv,
                              input logic act, input int h, input int v,
                              input logic shot, input logic kl);
    vec_t r;
    r.name = name; r.on_b = on_b; r.fire = f; r.tick = t; r.hitv = hv;
    r.ph = 10'(ph); r.pv = 10'(pv); r.act = act; r.h = 10'(h); r.v = 10'(v);
    r.shot = shot; r.kill = kl;
    return r;
  endfunction

  function automatic vec_t parked(input string name, input logic f, input logic t,
                                  input logic hv);
    return mk(name, 1'b0, f, t, hv, 100, 400, 1'b0, 0, 480, 1'b0, 1'b0);
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b, required %0b", name, act, exp);
    end
  endtask

  task automatic check_coord(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic compare_front();
    exp_t e;
    logic [22:0] got;
    e = exp_q.pop_front();
    got = e.on_b ? {b_act, b_h, b_v, b_shot, b_kill} : {a_act, a_h, a_v, a_shot, a_kill};
    checks++;
    if (got !== e.bits) begin
      errors++;
      $display("FAIL %s: got act=%0b h=%0d v=%0d shot=%0b kill=%0b, required act=%0b h=%0d v=%0d shot=%0b kill=%0b",
               e.name, got[22], got[21:12], got[11:2], got[1], got[0],
               e.bits[22], e.bits[21:12], e.bits[11:2], e.bits[1], e.bits[0]);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, then check after the rising edge.
  task automatic apply(input vec_t t);
    exp_t e;
    @(negedge clk);
    if (t.on_b) begin
      b_fire = t.fire; b_tick = t.tick; b_hit = t.hitv;
    end else begin
      fire_btn = t.fire; frame_tick = t.tick; hit = t.hitv;
    end
    player_h = t.ph;
    player_v = t.pv;
    e.name = t.name;
    e.on_b = t.on_b;
    e.bits = {t.act, t.h, t.v, t.shot, t.kill};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    fire_btn = 1'b1; frame_tick = 1'b0; hit = 1'b0;
    b_fire = 1'b0; b_tick = 1'b0; b_hit = 1'b0;
    player_h = 10'd100; player_v = 10'd400;

    #12;
    check_bit("reset_active", a_act, 1'b0);
    check_coord("reset_h", a_h, 10'd0);
    check_coord("reset_v", a_v, PV);
    check_bit("reset_shot", a_shot, 1'b0);
    check_bit("reset_kill", a_kill, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Launch after a held-through-reset button, then first flight.
    vecs.push_back(parked("held_thru_reset", 1'b1, 1'b0, 1'b0));
    vecs.push_back(parked("idle_release", 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("launch", 1'b0, 1'b1, 1'b1, 1'b0, 100, 400, 1'b1, 132, 336, 1'b1, 1'b0));
    vecs.push_back(mk("shot_one_cycle", 1'b0, 1'b1, 1'b0, 1'b0, 100, 400, 1'b1, 132, 336, 1'b0, 1'b0));
    run_vecs();

    for (int k = 1; k <= 84; k++)
      apply(mk($sformatf("climb_%0d", k), 1'b0, 1'b1, 1'b1, 1'b0, 100, 400,
               1'b1, 132, 336 - 4 * k, 1'b0, 1'b0));
    apply(parked("off_top_retire", 1'b1, 1'b1, 1'b0));

    // Cooldown: hit and fire edges ignored, IDLE after the 8th tick.
    apply(parked("hit_in_cooldown", 1'b1, 1'b1, 1'b1));
    for (int k = 2; k <= 7; k++)
      apply(parked($sformatf("cooldown_tick_%0d", k), k[0], 1'b1, 1'b0));
    apply(parked("cooldown_rise", 1'b1, 1'b0, 1'b0));
    apply(parked("cooldown_last_tick", 1'b1, 1'b1, 1'b0));
    apply(parked("no_autofire", 1'b1, 1'b0, 1'b0));
    apply(parked("hit_in_idle", 1'b1, 1'b0, 1'b1));

    // Second flight: hit outranks a simultaneous frame tick.
    vecs.push_back(parked("release_2", 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("launch_2", 1'b0, 1'b1, 1'b0, 1'b0, 100, 400, 1'b1, 132, 336, 1'b1, 1'b0));
    vecs.push_back(mk("step_2", 1'b0, 1'b1, 1'b1, 1'b0, 100, 400, 1'b1, 132, 332, 1'b0, 1'b0));
    vecs.push_back(mk("hit_priority", 1'b0, 1'b1, 1'b1, 1'b1, 100, 400, 1'b0, 0, 480, 1'b0, 1'b1));
    vecs.push_back(parked("kill_one_cycle", 1'b1, 1'b0, 1'b0));
    run_vecs();
    for (int k = 1; k <= 8; k++)
      apply(parked($sformatf("cooldown2_tick_%0d", k), 1'b1, 1'b1, 1'b0));

    // Third flight: horizontal truncation and vertical saturation.
    vecs.push_back(parked("release_3", 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk("sat_launch", 1'b0, 1'b1, 1'b0, 1'b0, 1000, 30, 1'b1, 8, 0, 1'b1, 1'b0));
    vecs.push_back(parked("sat_retire", 1'b1, 1'b1, 1'b0));
    run_vecs();
    for (int k = 1; k <= 8; k++)
      apply(parked($sformatf("cooldown3_tick_%0d", k), 1'b1, 1'b1, 1'b0));

    // Fourth flight up to v=200, then reset mid-flight.
    apply(parked("release_4", 1'b0, 1'b0, 1'b0));
    apply(mk("launch_4", 1'b0, 1'b1, 1'b0, 1'b0, 100, 400, 1'b1, 132, 336, 1'b1, 1'b0));
    for (int k = 1; k <= 34; k++)
      apply(mk($sformatf("climb4_%0d", k), 1'b0, 1'b1, 1'b1, 1'b0, 100, 400,
               1'b1, 132, 336 - 4 * k, 1'b0, 1'b0));
    frame_tick = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("midflight_reset_active", a_act, 1'b0);
    check_coord("midflight_reset_h", a_h, 10'd0);
    check_coord("midflight_reset_v", a_v, PV);
    check_bit("midflight_reset_kill", a_kill, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++)
      apply(parked($sformatf("no_launch_after_reset_%0d", k), 1'b1, 1'b0, 1'b0));

    // Zero-cooldown build: relaunch possible right after retire.
    vecs.push_back(mk("b_idle", 1'b1, 1'b0, 1'b0, 1'b0, 100, 70, 1'b0, 0, 480, 1'b0, 1'b0));
    vecs.push_back(mk("b_launch", 1'b1, 1'b1, 1'b0, 1'b0, 100, 70, 1'b1, 132, 6, 1'b1, 1'b0));
    vecs.push_back(mk("b_step", 1'b1, 1'b1, 1'b1, 1'b0, 100, 70, 1'b1, 132, 2, 1'b0, 1'b0));
    vecs.push_back(mk("b_retire", 1'b1, 1'b1, 1'b1, 1'b0, 100, 70, 1'b0, 0, 480, 1'b0, 1'b0));
    vecs.push_back(mk("b_release", 1'b1, 1'b0, 1'b0, 1'b0, 100, 70, 1'b0, 0, 480, 1'b0, 1'b0));
    vecs.push_back(mk("b_relaunch", 1'b1, 1'b1, 1'b0, 1'b0, 100, 70, 1'b1, 132, 6, 1'b1, 1'b0));
    run_vecs();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
